// File: rtl/reg_pc.sv
// Program-counter register for the fetch path: synchronous active-low reset,
// then load, then increment, else hold. data_out is driven straight from the flops.
module reg_pc #(
  parameter int               WIDTH       = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [WIDTH-1:0] INC_STEP    = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_enable,
  input  logic             inc,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  logic [WIDTH-1:0] pc;

  // Reset is tested first so unknowns on load_enable/inc cannot leak into pc.
  // The sum keeps WIDTH bits, which discards the carry and wraps the PC.
  always_ff @(posedge clk) begin
    if (!reset)           pc <= RESET_VALUE;
    else if (load_enable) pc <= data_in;
    else if (inc)         pc <= pc + INC_STEP;
  end

  assign data_out = pc;

endmodule

// File: tb/tb_reg_pc.sv
// Bench for reg_pc: directed steps from the test plan, then a random run,
// both checked against an integer model of the PC.
module tb_reg_pc;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset, load_enable, inc;
  logic [W-1:0] data_in;
  logic [W-1:0] data_out;

  int n_cmp  = 0;
  int n_fail = 0;
  int model_pc;
  bit model_ok = 1'b0;

  reg_pc #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_enable(load_enable),
    .inc        (inc),
    .data_in    (data_in),
    .data_out   (data_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs mid-cycle, confirm the output has not moved before
  // the edge, then advance the model and compare after the edge.
  task automatic step(input logic r, input logic ld, input logic in_c, input logic [W-1:0] din);
    @(negedge clk);
    reset = r; load_enable = ld; inc = in_c; data_in = din;
    #1;
    if (model_ok) chk("hold_before_edge", data_out, model_pc[W-1:0]);
    @(posedge clk);
    if (r === 1'b0)         model_pc = 0;
    else if (ld === 1'b1)   model_pc = int'(din);
    else if (in_c === 1'b1) model_pc = (model_pc + 1) % (1 << W);
    model_ok = 1'b1;
    #1;
    chk("model", data_out, model_pc[W-1:0]);
  endtask

  initial begin
    reset = 1'b1; load_enable = 1'b0; inc = 1'b0; data_in = '0;

    // Reset wins over load and increment
    step(0, 1, 1, 16'h1234); chk("reset_1", data_out, 16'h0000);
    step(0, 1, 1, 16'h1234); chk("reset_2", data_out, 16'h0000);

    // Increment run, then hold
    step(1, 0, 1, 16'h0); chk("inc_1", data_out, 16'h0001);
    step(1, 0, 1, 16'h0); chk("inc_2", data_out, 16'h0002);
    step(1, 0, 1, 16'h0); chk("inc_3", data_out, 16'h0003);
    step(1, 0, 1, 16'h0); chk("inc_4", data_out, 16'h0004);
    step(1, 0, 1, 16'h0); chk("inc_5", data_out, 16'h0005);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 16'hBEEF); chk("hold", data_out, 16'h0005);
    end

    // Load then count on
    step(1, 1, 0, 16'h00A0); chk("load", data_out, 16'h00A0);
    step(1, 0, 1, 16'h0);    chk("load_inc_1", data_out, 16'h00A1);
    step(1, 0, 1, 16'h0);    chk("load_inc_2", data_out, 16'h00A2);

    // Load has priority over increment
    step(1, 1, 0, 16'h0010); chk("preload", data_out, 16'h0010);
    step(1, 1, 1, 16'h0200); chk("load_beats_inc", data_out, 16'h0200);

    // Wrap-around
    step(1, 1, 0, 16'hFFFE); chk("load_fffe", data_out, 16'hFFFE);
    step(1, 0, 1, 16'h0);    chk("wrap_ffff", data_out, 16'hFFFF);
    step(1, 0, 1, 16'h0);    chk("wrap_0000", data_out, 16'h0000);
    step(1, 0, 1, 16'h0);    chk("wrap_0001", data_out, 16'h0001);

    // Reset in the middle of a count
    step(1, 1, 0, 16'h0040); chk("load_0040", data_out, 16'h0040);
    step(1, 0, 1, 16'h0);    chk("cnt_0041", data_out, 16'h0041);
    step(0, 0, 1, 16'h0);    chk("mid_reset", data_out, 16'h0000);
    step(1, 0, 1, 16'h0);    chk("post_reset", data_out, 16'h0001);

    // Unknown controls during reset must not reach the PC
    step(1, 1, 0, 16'h5555);
    step(0, 1'bx, 1'bx, 16'hxxxx); chk("reset_x_ctrl", data_out, 16'h0000);

    // Random run against the model, biased toward loads near the wrap point
    for (int i = 0; i < 400; i++) begin
      logic          r, ld, ic;
      logic [W-1:0]  d;
      r  = ($urandom_range(0, 19) != 0);
      ld = ($urandom_range(0, 3) == 0);
      ic = ($urandom_range(0, 1) == 1);
      d  = ($urandom_range(0, 3) == 0) ? W'(16'hFFFF - $urandom_range(0, 3)) : W'($urandom);
      step(r, ld, ic, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
